fft_stage_ctrl: RTL and testbench
=================================

// Module: fft_stage_ctrl
// PURPOSE
//  Sequencer for the in-place radix-2 DIT FFT engine behind the core's compute_fft state.
//  Reads from sample RAM arrive bit-reversed. On start, walks LOG2N stages x N/2 butterflies.
//  Issues one butterfly per cycle: RAM read addresses, twiddle index, and delayed write-back addresses.
//  Inserts a drain gap between stages to avoid RAW hazards, then pulses done for the core.
// PARAMETERS
//  LOG2N     6   log2 of FFT length N (N=64)
//  PIPE_LAT  3   cycles from rd_en to matching wr_en in butterfly datapath; must be >=1
// PORTS
//  clk        in   1            system clock, all state updates on rising edge
//  rstb       in   1            asynchronous active-low reset
//  start      in   1            start request; sampled only in IDLE
//  busy       out  1            high in RUN/DRAIN/DONE
//  done       out  1            one-cycle pulse at end of final stage drain
//  stage      out  $clog2(LOG2N) current stage index s
//  rd_en      out  1            butterfly read issue
//  rd_addr_a  out  LOG2N        upper-leg read address
//  rd_addr_b  out  LOG2N        lower-leg read address
//  tw_addr    out  LOG2N-1      twiddle ROM index
//  wr_en      out  1            rd_en delayed PIPE_LAT cycles
//  wr_addr_a  out  LOG2N        rd_addr_a delayed PIPE_LAT cycles
//  wr_addr_b  out  LOG2N        rd_addr_b delayed PIPE_LAT cycles
// BEHAVIOUR
//  Reset (async, rstb=0):
//   - state=IDLE; all outputs 0.
//   - Counters and write-delay pipeline cleared.
//   - Reset mid-run aborts immediately; no further rd_en/wr_en.
//  States and transitions:
//   - IDLE: start=1 -> RUN, s=0, k=0.
//   - RUN: rd_en=1 every cycle; k increments 0..N/2-1.
//     At k=N/2-1 -> DRAIN, k=0.
//   - DRAIN: rd_en=0 for exactly PIPE_LAT cycles; wr_en still follows the delay line.
//     Then: if s<LOG2N-1, s++ and -> RUN; else -> DONE.
//   - DONE: done=1 for one cycle, busy=1 -> IDLE.
//   - start outside IDLE is ignored, including during DONE; no queuing.
//  Address arithmetic, combinational from registered s,k:
//   - span=1<<s; grp=k>>s; pos=k&(span-1).
//   - rd_addr_a=(grp<<(s+1))|pos; rd_addr_b=rd_addr_a+span; tw_addr=pos<<(LOG2N-1-s).
//   - Outputs are unsigned with no overflow by construction; addr_b < N always.
//  Write-back:
//   - {wr_en, wr_addr_a, wr_addr_b} is a PIPE_LAT-deep shift of {rd_en, rd_addr_a, rd_addr_b}.
//  Hazard and timing:
//   - Last write of stage s lands in the final DRAIN cycle.
//   - First read of stage s+1 is the following cycle, so RAM holds committed data.
//  Timing, with cycle 0 = IDLE edge where start sampled:
//   - Stage s reads occupy cycles 1+s*(N/2+PIPE_LAT) .. +N/2-1.
//   - done is high at cycle 1+LOG2N*(N/2+PIPE_LAT); that is 211 for the defaults.
//   - busy rises at cycle 1 and falls after done.
//  Counts: exactly LOG2N*N/2 rd_en pulses and the same number of wr_en pulses per run (192 default).
// TESTING
//  1 Reset: rstb=0 with start=1 -> all outputs 0, stays IDLE; release -> first rd_en one cycle after start sampled.
//  2 Stage 0: k=0 -> a=0,b=1,tw=0; k=1 -> a=2,b=3,tw=0. Stage 1, k=1 -> a=1,b=3,tw=16.
//  3 Stage 2, k=5 -> a=9,b=13,tw=8. Stage 5, k=31 -> a=31,b=63,tw=31.
//    wr_addr matches rd_addr exactly 3 cycles later.
//  4 Full run: done at cycle 211; 192 rd_en and 192 wr_en pulses.
//    Each stage has a 3-cycle rd_en gap; no read of stage s+1 before its last write.
//  5 start held high through the run and during DONE -> exactly one run.
//    A new run starts only if start is high in IDLE after DONE.
//  6 rstb pulsed low at cycle 100 -> outputs 0 asynchronously; pending wr_en flushed.
//    Clean start afterwards reproduces scenario 4 timing.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 DIT FFT engine.
// Issues one butterfly read per cycle, delays it into write-back, and drains between stages.
module fft_stage_ctrl #(
    parameter int unsigned LOG2N    = 6,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);

    localparam int unsigned AW = LOG2N;
    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned DW = $clog2(PIPE_LAT + 1);
    localparam int unsigned WBW = 2 * AW + 1;

    localparam logic [KW-1:0] LAST_K     = KW'((1 << KW) - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);
    localparam logic [SW-1:0] TW_SHIFT   = SW'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [SW-1:0] s, s_d;
    logic [KW-1:0] k, k_d;
    logic [DW-1:0] dcnt, dcnt_d;

    // Address arithmetic on the next-cycle counters so the outputs leave flops
    logic [AW-1:0] kx, span, pos, grp;
    logic [AW-1:0] addr_a_d, addr_b_d;
    logic [KW-1:0] tw_d;
    logic          rd_en_d;

    logic [WBW-1:0] pipe [PIPE_LAT];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
            s     <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_d;
            s     <= s_d;
            k     <= k_d;
            dcnt  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state;
        s_d     = s;
        k_d     = k;
        dcnt_d  = dcnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (k == LAST_K) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                    dcnt_d  = '0;
                end else begin
                    k_d = k + KW'(1);
                end
            end
            S_DRAIN: begin
                // Hold reads off until the last write of this stage has landed
                if (dcnt == LAST_DRAIN) begin
                    dcnt_d = '0;
                    if (s < LAST_STAGE) begin
                        s_d     = s + SW'(1);
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    dcnt_d = dcnt + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                s_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en_d  = (state_d == S_RUN);
        kx       = AW'(k_d);
        span     = AW'(1) << s_d;
        pos      = kx & (span - AW'(1));
        grp      = kx >> s_d;
        addr_a_d = ((grp << s_d) << 1) | pos;
        addr_b_d = addr_a_d + span;
        tw_d     = KW'(pos << (TW_SHIFT - s_d));
        // Addresses are parked at zero whenever no read is issued
        if (!rd_en_d) begin
            addr_a_d = '0;
            addr_b_d = '0;
            tw_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            stage     <= s_d;
            rd_en     <= rd_en_d;
            rd_addr_a <= addr_a_d;
            rd_addr_b <= addr_b_d;
            tw_addr   <= tw_d;
        end
    end

    // Write-back delay line matching the butterfly datapath latency
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: cycle-indexed reference of the stage schedule and butterfly addressing.
module tb_fft_stage_ctrl;

    localparam int LOG2N   = 6;
    localparam int LAT     = 3;
    localparam int NH      = 1 << (LOG2N - 1);
    localparam int PER     = NH + LAT;
    localparam int DONE_C  = 1 + LOG2N * PER;
    localparam int PULSES  = LOG2N * NH;

    logic       clk;
    logic       rstb;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [5:0] rd_addr_a;
    logic [5:0] rd_addr_b;
    logic [4:0] tw_addr;
    logic       wr_en;
    logic [5:0] wr_addr_a;
    logic [5:0] wr_addr_b;

    int n_cmp = 0;
    int n_err = 0;

    fft_stage_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(LAT)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Butterfly read expected at cycle c of a run (cycle 1 = first cycle after start sampled)
    function automatic void ref_read(input int c, output bit en, output int a, output int b,
                                     output int tw);
        int t, s, r, span, pos;
        en = 1'b0;
        a  = 0;
        b  = 0;
        tw = 0;
        t  = c - 1;
        if (c >= 1 && t < LOG2N * PER) begin
            s = t / PER;
            r = t % PER;
            if (r < NH) begin
                en   = 1'b1;
                span = 1 << s;
                pos  = r % span;
                a    = (r / span) * 2 * span + pos;
                b    = a + span;
                tw   = pos * (1 << (LOG2N - 1 - s));
            end
        end
    endfunction

    task automatic check_cycle(input int c, inout int nrd, inout int nwr, inout int ndone);
        bit en, wen;
        int a, b, tw, wa, wb, wtw, exp_stage;
        bit exp_busy;
        ref_read(c, en, a, b, tw);
        ref_read(c - LAT, wen, wa, wb, wtw);
        exp_busy = (c >= 1 && c <= DONE_C);
        check($sformatf("busy@%0d", c), 32'(busy), 32'(exp_busy));
        check($sformatf("done@%0d", c), 32'(done), 32'(c == DONE_C));
        check($sformatf("rd_en@%0d", c), 32'(rd_en), 32'(en));
        check($sformatf("wr_en@%0d", c), 32'(wr_en), 32'(wen));
        if (exp_busy) begin
            exp_stage = (c - 1) / PER;
            if (exp_stage > LOG2N - 1) exp_stage = LOG2N - 1;
            check($sformatf("stage@%0d", c), 32'(stage), 32'(exp_stage));
        end
        if (en) begin
            check($sformatf("rd_addr_a@%0d", c), 32'(rd_addr_a), 32'(a));
            check($sformatf("rd_addr_b@%0d", c), 32'(rd_addr_b), 32'(b));
            check($sformatf("tw_addr@%0d", c), 32'(tw_addr), 32'(tw));
        end
        if (wen) begin
            check($sformatf("wr_addr_a@%0d", c), 32'(wr_addr_a), 32'(wa));
            check($sformatf("wr_addr_b@%0d", c), 32'(wr_addr_b), 32'(wb));
        end
        nrd   += int'(rd_en);
        nwr   += int'(wr_en);
        ndone += int'(done);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_stage"}, 32'(stage), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_addr"}, 32'({rd_addr_a, rd_addr_b, tw_addr}), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'({wr_addr_a, wr_addr_b}), 0);
    endtask

    task automatic check_counts(input string tag, input int nrd, input int nwr, input int ndone);
        check({tag, "_rd_pulses"}, 32'(nrd), 32'(PULSES));
        check({tag, "_wr_pulses"}, 32'(nwr), 32'(PULSES));
        check({tag, "_done_pulses"}, 32'(ndone), 1);
    endtask

    initial begin
        int nrd, nwr, ndone, gap;
        rstb  = 1'b0;
        start = 1'b1;

        // Held in reset with start asserted: nothing moves
        repeat (3) begin
            @(negedge clk);
            check_zero("reset");
        end
        rstb = 1'b1;

        // start held high for the whole run and through DONE
        nrd = 0; nwr = 0; ndone = 0;
        for (int c = 1; c <= DONE_C + 1; c++) begin
            @(negedge clk);
            check_cycle(c, nrd, nwr, ndone);
        end
        check_counts("held_run", nrd, nwr, ndone);

        // start still high in IDLE after DONE launches exactly one new run; abort it at cycle 100
        nrd = 0; nwr = 0; ndone = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            check_cycle(c, nrd, nwr, ndone);
        end
        #2 rstb = 1'b0;
        #1 check_zero("async_rst");
        start = 1'b0;
        @(negedge clk);
        check_zero("rst_hold");
        rstb = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_zero("post_rst");
        end

        // Randomised start activity: only the first assertion in IDLE counts
        for (int run = 0; run < 3; run++) begin
            gap = int'($urandom_range(0, 4));
            repeat (gap) begin
                @(negedge clk);
                check("idle_busy", 32'(busy), 0);
                check("idle_rd_en", 32'(rd_en), 0);
                check("idle_wr_en", 32'(wr_en), 0);
            end
            start = 1'b1;
            nrd = 0; nwr = 0; ndone = 0;
            for (int c = 1; c <= DONE_C + 1; c++) begin
                @(negedge clk);
                check_cycle(c, nrd, nwr, ndone);
                start = (c <= DONE_C) ? 1'($urandom % 2) : 1'b0;
            end
            check_counts($sformatf("rand_run%0d", run), nrd, nwr, ndone);
            repeat (3) begin
                @(negedge clk);
                check("after_busy", 32'(busy), 0);
                check("after_rd_en", 32'(rd_en), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
